// File: rtl/data_mem_pkg.sv
// Shared constants, FSM encoding and helpers for the RV32 load/store data memory.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } lsu_rsp_t;

  // Stores only have signed-agnostic sizes; loads add the unsigned variants.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response channel between the mem stage and the data memory.
interface data_mem_lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_align.sv
// Byte-lane steering: store lane replication/byte enables, misalign check,
// and load extraction with sign/zero extension.
module dmem_align
  import data_mem_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [1:0]           off,
  input  logic [31:0]          wdata,
  input  logic [31:0]          rword,
  output logic [31:0]          wlanes,
  output logic [NUM_LANES-1:0] be,
  output logic                 misaligned,
  output logic [31:0]          rdata
);
  logic [1:0]  size;
  logic [31:0] sh;
  logic        sgn;

  assign size = funct3[1:0];

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      localparam logic [1:0] LANE = 2'(i);
      assign be[i] = (size == 2'b00) ? (off == LANE) :
                     (size == 2'b01) ? (off[1] == LANE[1]) :
                     (size == 2'b10);
      assign wlanes[8*i +: 8] = (size == 2'b00) ? wdata[7:0] :
                                (size == 2'b01) ? wdata[8*(i%2) +: 8] :
                                wdata[8*i +: 8];
    end
  endgenerate

  assign misaligned = ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));

  assign sh  = rword >> {off, 3'b000};
  assign sgn = ~funct3[2];

  always_comb begin
    rdata = rword;
    case (size)
      2'b00:   rdata = {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   rdata = {{16{sgn & sh[15]}}, sh[15:0]};
      default: rdata = rword;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressed RV32 data memory with valid/ready requests, programmable
// wait states and a one-cycle response pulse carrying data or an error.
module data_mem_lsu
  import data_mem_pkg::*;
#(
  parameter int    MEM_DEPTH   = 256,
  parameter int    ADDR_WIDTH  = 32,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_lsu_if.slave  bus
);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int WW = ADDR_WIDTH - 2;

  logic [31:0]          mem [MEM_DEPTH];
  logic [1:0]           state;
  logic [3:0]           cnt;
  lsu_rsp_t             hold;
  lsu_rsp_t             cur;

  logic [WW-1:0]        widx;
  logic [IW-1:0]        mem_idx;
  logic [1:0]           off;
  logic                 accept, oor, mis, err, wr_en;
  logic [31:0]          rword, wlanes, ld_data;
  logic [NUM_LANES-1:0] be;

  // Array init only; contents are deliberately untouched by reset.
  initial begin
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
  end

  assign widx    = bus.req_addr[ADDR_WIDTH-1:2];
  assign off     = bus.req_addr[1:0];
  assign mem_idx = widx[IW-1:0];
  assign oor     = (64'(widx) >= 64'(MEM_DEPTH));
  assign rword   = oor ? '0 : mem[mem_idx];

  dmem_align u_align (
    .funct3     (bus.req_funct3),
    .off        (off),
    .wdata      (bus.req_wdata),
    .rword      (rword),
    .wlanes     (wlanes),
    .be         (be),
    .misaligned (mis),
    .rdata      (ld_data)
  );

  assign err           = oor | mis | ~f3_legal(bus.req_we, bus.req_funct3);
  assign bus.req_ready = (state != ST_WAIT);
  assign bus.rsp_valid = (state == ST_RESP);
  assign accept        = bus.req_valid & bus.req_ready;
  assign wr_en         = accept & bus.req_we & ~err;

  // Load result is resolved at accept so a store on the next edge cannot alter it.
  assign cur.err  = err;
  assign cur.data = (err || bus.req_we) ? '0 : ld_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (be[i]) mem[mem_idx][8*i +: 8] <= wlanes[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      hold          <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (cnt == '0) begin
            state         <= ST_RESP;
            bus.rsp_rdata <= hold.data;
            bus.rsp_err   <= hold.err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if (accept) begin
            if (WAIT_STATES == 0) begin
              state         <= ST_RESP;
              bus.rsp_rdata <= cur.data;
              bus.rsp_err   <= cur.err;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
              hold  <= cur;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
